vram_write_queue: RTL and testbench
===================================

Name: vram_write_queue

Overview:
- Sits directly downstream of the core's MEM-stage video tap and consumes video_we/video_addr/video_data.
- The core cannot be stalled by video traffic, so every store is accepted, filtered and buffered in an in-order FIFO.
- The FIFO drains into the framebuffer's single write port whenever the display scanner grants access.
- Drops and overflows are reported through status outputs; nothing backpressures the core.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- VRAM_BASE, 32'h00008000, byte address of framebuffer word 0.
- VRAM_WORDS, 16384, framebuffer size in 32-bit words.
- VADDR_W, 14, width of the framebuffer word address; must satisfy 2^VADDR_W >= VRAM_WORDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- video_we  input  1  store request from the core MEM stage.
- video_addr  input  32  store byte address.
- video_data  input  32  store data word.
- vram_grant  input  1  display scanner releases the framebuffer port this cycle.
- clear_status  input  1  synchronous clear of overflow and drop_count.
- vram_we  output  1  framebuffer write strobe.
- vram_waddr  output  VADDR_W  framebuffer word address.
- vram_wdata  output  32  framebuffer write data.
- fifo_count  output  log2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a valid store was lost because the FIFO was full.
- drop_count  output  16  stores discarded for any reason; saturates at 16'hFFFF.
- idle  output  1  FIFO empty.

Behaviour:
- Reset (asynchronous, immediate) clears:
  - read pointer, write pointer and fifo_count to 0;
  - overflow to 0 and drop_count to 0.
- Reset consequences and mid-operation behaviour:
  - After reset, vram_we=0 and idle=1.
  - Entry storage is not reset.
  - Reset asserted mid-operation discards all queued entries; no partial write is issued after rst rises.
- Acceptance filter, evaluated when video_we=1:
  - off = video_addr - VRAM_BASE;
  - valid = (video_addr >= VRAM_BASE) && (video_addr[1:0]==0) && ((off>>2) < VRAM_WORDS).
  - The stored entry is {off[VADDR_W+1:2], video_data}.
- Push rule: push = video_we && valid && (!full || pop).
  - Full with a simultaneous pop still accepts the push; count stays at DEPTH.
- Drop event: video_we && (!valid || (full && !pop)).
  - Each drop event increments drop_count by 1 (saturating).
  - The full-and-no-pop case also sets overflow.
- Drain rule, combinational from registered state:
  - vram_we = !empty && vram_grant.
  - vram_waddr and vram_wdata always present the head entry (held stable while empty is undefined-free: they show the last head value).
  - pop = vram_we; the head advances on the same edge.
- Latency: a store sampled at edge N can produce vram_we in the cycle after N, if grant=1. No bypass from input to output.
- Ordering:
  - Strict FIFO order.
  - Repeated stores to the same address are all written, in order; no merging.
- Simultaneous push and pop: fifo_count is unchanged; both pointers advance.
- Push when empty: the entry becomes the head at the next edge.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- clear_status: at the edge it is high, overflow and drop_count are cleared first, then that cycle's event is applied.
  - A drop coincident with a clear leaves drop_count=1.
  - An overflow coincident with a clear leaves overflow=1.
- The FIFO contents are never affected by clear_status.
- idle = empty; it deasserts in the cycle after the first push.

Test Plan:
1. Reset, then three stores to 0x8000, 0x8004, 0x8008 with data 1, 2, 3 on consecutive cycles, grant held high -> vram_we on 3 consecutive cycles starting one cycle after the first store, with waddr 0, 1, 2 and data 1, 2, 3; idle returns to 1.
2. Grant low, 10 valid stores with DEPTH=8 -> fifo_count=8, overflow=1, drop_count=2. Raise grant -> first 8 stores written in order, then idle=1.
3. Stores to 0x7FFC, to 0x8002, and to VRAM_BASE+4*VRAM_WORDS -> no push; drop_count=3, overflow stays 0.
4. FIFO full with grant high and a store in the same cycle -> push accepted, count stays 8, no drop; written data sequence is in order.
5. clear_status asserted in the same cycle as a full-FIFO drop -> overflow=1, drop_count=1 on the next cycle.
6. Assert rst asynchronously mid-drain with 5 entries queued -> vram_we falls without waiting for a clock edge; fifo_count=0, idle=1, and no further writes occur after release.

Source files
------------

// File: rtl/vram_write_queue_if.sv
// Video store tap and framebuffer write port between the core, the write
// queue and the framebuffer.
// Handshake: the video side has no ready. A store is offered for exactly the
// cycle video_we is high and is never retried. On the framebuffer side,
// vram_we rises only when vram_grant is high and an entry is queued.
// Address and data are consumed on the rising edge that ends that cycle.
interface vram_write_queue_if #(
   parameter int VADDR_W = 14
);
   logic               video_we;
   logic [31:0]        video_addr;
   logic [31:0]        video_data;
   logic               vram_grant;
   logic               vram_we;
   logic [VADDR_W-1:0] vram_waddr;
   logic [31:0]        vram_wdata;

   // Core/scanner side: drives stores and grant, observes framebuffer writes.
   modport master (
      output video_we, video_addr, video_data, vram_grant,
      input  vram_we, vram_waddr, vram_wdata
   );

   // Queue side.
   modport slave (
      input  video_we, video_addr, video_data, vram_grant,
      output vram_we, vram_waddr, vram_wdata
   );
endinterface

// File: rtl/vram_write_queue.sv
// In-order write buffer between the core's video store tap and the
// framebuffer write port. Every store is accepted without stalling the core.
// Stores outside the framebuffer or misaligned are dropped. Stores that
// arrive while the queue is full and not draining are dropped and flagged as
// overflow.
module vram_write_queue #(
   parameter int          DEPTH      = 8,
   parameter logic [31:0] VRAM_BASE  = 32'h0000_8000,
   parameter int          VRAM_WORDS = 16384,
   parameter int          VADDR_W    = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   vram_write_queue_if.slave        bus,
   input  logic                     clear_status,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [15:0]              drop_count,
   output logic                     idle
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int EW    = VADDR_W + 32;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [31:0]      WORDS_32  = 32'(VRAM_WORDS);

   logic [EW-1:0]    mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;

   logic [31:0] addr_off;
   logic [31:0] word_off;
   logic        addr_ok;
   logic        full, empty;
   logic        push, pop;
   logic        drop_evt, ovf_evt;
   logic [15:0] drop_base, drop_next;
   logic        ovf_next;
   logic [EW-1:0] head;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Acceptance filter and push/pop/drop decisions for this cycle.
   always_comb begin
      addr_off = bus.video_addr - VRAM_BASE;
      word_off = {2'b00, addr_off[31:2]};
      addr_ok  = (bus.video_addr >= VRAM_BASE) && (bus.video_addr[1:0] == 2'b00)
                 && (word_off < WORDS_32);
      pop      = !empty && bus.vram_grant;
      push     = bus.video_we && addr_ok && (!full || pop);
      ovf_evt  = bus.video_we && addr_ok && full && !pop;
      drop_evt = bus.video_we && (!addr_ok || (full && !pop));
   end

   // Status next state: clear applies first, then this cycle's event.
   always_comb begin
      drop_base = clear_status ? 16'h0000 : drop_count;
      drop_next = drop_base;
      if (drop_evt && (drop_base != 16'hFFFF)) begin
         drop_next = drop_base + 16'h0001;
      end
      ovf_next = (clear_status ? 1'b0 : overflow) | ovf_evt;
   end

   // Entry storage; deliberately not reset, only the pointers matter.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {addr_off[VADDR_W+1:2], bus.video_data};
      end
   end

   // Pointers and occupancy; reset discards everything queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= 16'h0000;
      end else begin
         overflow   <= ovf_next;
         drop_count <= drop_next;
      end
   end

   // Head entry always visible; the strobe depends only on registered state and grant.
   assign head           = mem[rd_ptr];
   assign bus.vram_we    = pop;
   assign bus.vram_waddr = head[EW-1:32];
   assign bus.vram_wdata = head[31:0];
   assign fifo_count     = count;
   assign idle           = empty;
endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue: store bursts, filter rejects, full
// with simultaneous drain, status clear and asynchronous reset mid-drain.
module tb_vram_write_queue;
   logic        clk;
   logic        rst;
   logic        clear_status;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic [15:0] drop_count;
   logic        idle;

   int checks = 0;
   int passes = 0;
   logic [45:0] exp_q[$];

   vram_write_queue_if #(.VADDR_W(14)) vif();

   vram_write_queue #(
      .DEPTH(8), .VRAM_BASE(32'h0000_8000), .VRAM_WORDS(16384), .VADDR_W(14)
   ) dut (
      .clk(clk), .rst(rst), .bus(vif.slave), .clear_status(clear_status),
      .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
      .idle(idle)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every framebuffer write must match the oldest expected entry.
   always @(negedge clk) begin
      if (vif.vram_we) begin
         checks++;
         assert (exp_q.size() != 0) passes++;
         else $error("FAIL unexpected_write obs=%0h_%0h exp=none", vif.vram_waddr, vif.vram_wdata);
         if (exp_q.size() != 0) begin
            logic [45:0] e;
            e = exp_q.pop_front();
            checks++;
            assert ({vif.vram_waddr, vif.vram_wdata} === e) passes++;
            else $error("FAIL write_order obs=%0h_%0h exp=%0h_%0h",
                        vif.vram_waddr, vif.vram_wdata, e[45:32], e[31:0]);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      vif.video_we   = 1'b1;
      vif.video_addr = addr;
      vif.video_data = data;
      tick();
      vif.video_we   = 1'b0;
   endtask

   task automatic drain_until_idle(input string tag);
      for (int n = 0; n < 20 && !idle; n++) tick();
      chk(tag, 32'(idle), 32'd1);
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic clear_stats();
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      clear_status   = 1'b0;
      vif.video_we   = 1'b0;
      vif.video_addr = 32'h0;
      vif.video_data = 32'h0;
      vif.vram_grant = 1'b1;
      #2;
      // Reset state, with grant high so the strobe check means something.
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_vram_we", 32'(vif.vram_we), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // 1: three stores with grant high, one-cycle latency, in order.
      exp_q.push_back({14'd0, 32'd1});
      exp_q.push_back({14'd1, 32'd2});
      exp_q.push_back({14'd2, 32'd3});
      store(32'h8000, 32'd1);
      chk("t1_we_after_first", 32'(vif.vram_we), 32'd1);
      chk("t1_idle_low", 32'(idle), 32'd0);
      chk("t1_count1", 32'(fifo_count), 32'd1);
      store(32'h8004, 32'd2);
      chk("t1_count_pushpop", 32'(fifo_count), 32'd1);
      store(32'h8008, 32'd3);
      chk("t1_count_pushpop2", 32'(fifo_count), 32'd1);
      tick();
      chk("t1_idle", 32'(idle), 32'd1);
      chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

      // 2: grant low, ten stores into eight slots.
      vif.vram_grant = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) exp_q.push_back({14'(i), 32'h100 + 32'(i)});
         store(32'h8000 + 32'(4 * i), 32'h100 + 32'(i));
      end
      chk("t2_count_full", 32'(fifo_count), 32'd8);
      chk("t2_overflow", 32'(overflow), 32'd1);
      chk("t2_drop", 32'(drop_count), 32'd2);
      chk("t2_no_we", 32'(vif.vram_we), 32'd0);
      vif.vram_grant = 1'b1;
      drain_until_idle("t2_idle");
      clear_stats();
      chk("t2_clear_ovf", 32'(overflow), 32'd0);
      chk("t2_clear_drop", 32'(drop_count), 32'd0);

      // 3: below base, misaligned, one past the end.
      store(32'h7FFC, 32'hA);
      store(32'h8002, 32'hB);
      store(32'h8000 + 32'(4 * 16384), 32'hC);
      tick();
      chk("t3_drop", 32'(drop_count), 32'd3);
      chk("t3_overflow", 32'(overflow), 32'd0);
      chk("t3_count", 32'(fifo_count), 32'd0);
      chk("t3_idle", 32'(idle), 32'd1);
      clear_stats();

      // 4: full queue, grant and store in the same cycle.
      vif.vram_grant = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({14'(i), 32'h200 + 32'(i)});
         store(32'h8000 + 32'(4 * i), 32'h200 + 32'(i));
      end
      chk("t4_count_full", 32'(fifo_count), 32'd8);
      exp_q.push_back({14'h40, 32'h2FF});
      vif.vram_grant = 1'b1;
      store(32'h8100, 32'h2FF);
      chk("t4_count_stays", 32'(fifo_count), 32'd8);
      chk("t4_no_drop", 32'(drop_count), 32'd0);
      chk("t4_no_overflow", 32'(overflow), 32'd0);
      drain_until_idle("t4_idle");

      // 5: clear coincident with a full-queue drop.
      vif.vram_grant = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({14'(8 + i), 32'h300 + 32'(i)});
         store(32'h8020 + 32'(4 * i), 32'h300 + 32'(i));
      end
      store(32'h8040, 32'h3F8);
      chk("t5_pre_drop", 32'(drop_count), 32'd1);
      chk("t5_pre_ovf", 32'(overflow), 32'd1);
      clear_status = 1'b1;
      store(32'h8044, 32'h3F9);
      clear_status = 1'b0;
      chk("t5_clear_drop", 32'(drop_count), 32'd1);
      chk("t5_clear_ovf", 32'(overflow), 32'd1);
      chk("t5_count", 32'(fifo_count), 32'd8);
      vif.vram_grant = 1'b1;
      drain_until_idle("t5_idle");
      clear_stats();
      chk("t5_cleared", 32'({overflow, drop_count}), 32'd0);

      // 6: asynchronous reset with five entries still queued.
      vif.vram_grant = 1'b0;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back({14'(32 + i), 32'h400 + 32'(i)});
         store(32'h8080 + 32'(4 * i), 32'h400 + 32'(i));
      end
      vif.vram_grant = 1'b1;
      tick();
      tick();
      chk("t6_count5", 32'(fifo_count), 32'd5);
      chk("t6_we_pre", 32'(vif.vram_we), 32'd1);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("t6_we_async", 32'(vif.vram_we), 32'd0);
      chk("t6_count0", 32'(fifo_count), 32'd0);
      chk("t6_idle", 32'(idle), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      for (int n = 0; n < 6; n++) tick();
      chk("t6_still_idle", 32'(idle), 32'd1);
      chk("t6_still_count0", 32'(fifo_count), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
